mem_bus_arbiter: RTL and testbench

- Shares the single memory-controller port (valid/RW/ready handshake) between the instruction-fetch requester and the load/store requester of the control unit.
- Sequences each access through the controller's two-phase ready handshake: ready falls when busy, rises when done.
- Returns read data and a one-cycle completion pulse to the owning requester.
- Guards against a hung controller with a timeout.

---
 rtl/mem_bus_arbiter_pkg.sv | 19 +
 rtl/mem_bus_arbiter_arb_priority.sv | 44 ++++
 rtl/mem_bus_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared types and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_LOW  = 2'd1,
        WAIT_HIGH = 2'd2,
        RELEASE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_FETCH = 1'b0,
        OWN_DATA  = 1'b1
    } arb_owner_t;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/mem_bus_arbiter_arb_priority.sv
// rtl/mem_bus_arbiter_arb_priority.sv - data-first owner select with fetch anti-starvation streak
module arb_priority
    import mem_bus_arbiter_pkg::*;
#(
    parameter int MAX_STREAK = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       f_req,
    input  logic       d_req,
    input  logic       grant,
    output arb_owner_t owner
);

    localparam int SW = $clog2(MAX_STREAK + 1);

    logic [SW-1:0] r_streak;
    logic          w_force_fetch;

    assign w_force_fetch = f_req && (r_streak == SW'(MAX_STREAK));

    always_comb begin
        owner = OWN_DATA;
        if (!d_req || w_force_fetch) begin
            owner = OWN_FETCH;
        end
    end

    // Streak counts data grants that bypassed a waiting fetch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_streak <= '0;
        end else if (grant) begin
            if (owner == OWN_DATA && f_req) begin
                if (r_streak != SW'(MAX_STREAK)) begin
                    r_streak <= r_streak + SW'(1);
                end
            end else begin
                r_streak <= '0;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one ready-handshake memory port between fetch and load/store
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int MAX_STREAK = 4,
    parameter int TIMEOUT    = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_done,
    output logic [DW-1:0] f_rdata,
    input  logic          d_req,
    input  logic          d_rw,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_done,
    output logic [DW-1:0] d_rdata,
    output logic          m_valid,
    output logic          m_rw,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic          m_ready,
    input  logic [DW-1:0] m_rdata,
    output logic          busy,
    output logic          err
);

    localparam int TCW = $clog2(TIMEOUT + 1);

    arb_state_t     r_state, w_state_nxt;
    arb_owner_t     r_owner, w_owner;
    logic           w_grant, w_finish, w_abort, w_tmo;
    logic [TCW-1:0] r_tcnt;
    logic [DW-1:0]  w_cap;
    logic           r_m_valid, r_m_rw, r_f_done, r_d_done, r_err;
    logic [AW-1:0]  r_m_addr;
    logic [DW-1:0]  r_m_wdata, r_f_rdata, r_d_rdata;

    arb_priority #(.MAX_STREAK(MAX_STREAK)) u_prio (
        .clk   (clk),
        .reset (reset),
        .f_req (f_req),
        .d_req (d_req),
        .grant (w_grant),
        .owner (w_owner)
    );

    assign w_tmo = (r_tcnt == TCW'(TIMEOUT - 1));
    assign w_cap = (w_finish && r_m_rw == RW_READ) ? m_rdata : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A controller completion seen on the same edge as the timeout wins.
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_finish    = 1'b0;
        w_abort     = 1'b0;
        case (r_state)
            IDLE: begin
                if (f_req || d_req) begin
                    w_grant     = 1'b1;
                    w_state_nxt = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (!m_ready) begin
                    w_state_nxt = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (m_ready) begin
                    w_finish    = 1'b1;
                    w_state_nxt = RELEASE;
                end else if (w_tmo) begin
                    w_abort     = 1'b1;
                    w_state_nxt = RELEASE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_owner   <= OWN_FETCH;
            r_tcnt    <= '0;
            r_m_valid <= 1'b0;
            r_m_rw    <= 1'b0;
            r_m_addr  <= '0;
            r_m_wdata <= '0;
            r_f_done  <= 1'b0;
            r_d_done  <= 1'b0;
            r_err     <= 1'b0;
            r_f_rdata <= '0;
            r_d_rdata <= '0;
        end else begin
            r_f_done <= 1'b0;
            r_d_done <= 1'b0;
            r_err    <= 1'b0;
            r_tcnt   <= (r_state == WAIT_LOW || r_state == WAIT_HIGH) ? r_tcnt + TCW'(1) : '0;
            if (w_grant) begin
                r_owner   <= w_owner;
                r_m_valid <= 1'b1;
                r_m_rw    <= (w_owner == OWN_FETCH) ? RW_READ : d_rw;
                r_m_addr  <= (w_owner == OWN_FETCH) ? f_addr : d_addr;
                r_m_wdata <= (w_owner == OWN_FETCH) ? '0 : d_wdata;
            end
            if (w_finish || w_abort) begin
                r_m_valid <= 1'b0;
                r_err     <= w_abort;
                if (r_owner == OWN_FETCH) begin
                    r_f_done  <= 1'b1;
                    r_f_rdata <= w_cap;
                end else begin
                    r_d_done  <= 1'b1;
                    r_d_rdata <= w_cap;
                end
            end
        end
    end

    assign f_done  = r_f_done;
    assign f_rdata = r_f_rdata;
    assign d_done  = r_d_done;
    assign d_rdata = r_d_rdata;
    assign m_valid = r_m_valid;
    assign m_rw    = r_m_rw;
    assign m_addr  = r_m_addr;
    assign m_wdata = r_m_wdata;
    assign err     = r_err;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_req, d_req, d_rw, m_ready;
    logic [31:0] f_addr, d_addr, d_wdata, m_rdata;
    logic        f_done, d_done, m_valid, m_rw, busy, err;
    logic [31:0] f_rdata, d_rdata, m_addr, m_wdata;

    int checks = 0;
    int errors = 0;

    mem_bus_arbiter #(.AW(32), .DW(32), .MAX_STREAK(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata),
        .d_req(d_req), .d_rw(d_rw), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata),
        .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rdata(m_rdata), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Serves one access: waits for m_valid, drops then raises ready, reports which done pulsed.
    task automatic run_one(input logic [31:0] rdata, output logic was_data, output logic ok);
        int n;
        n = 0;
        ok = 1'b1;
        was_data = 1'b0;
        while (m_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (m_valid !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        m_ready = 1'b0;
        tick();
        m_ready = 1'b1;
        m_rdata = rdata;
        tick();
        was_data = d_done;
        ok = ((f_done ^ d_done) === 1'b1);
        if (d_done === 1'b1) d_req = 1'b0;
        else if (f_done === 1'b1) f_req = 1'b0;
        tick();
    endtask

    initial begin
        logic       was_data, ok, seen;
        logic [5:0] order;

        reset = 1'b0;
        f_req = 1'b0; d_req = 1'b0; d_rw = 1'b0; m_ready = 1'b1;
        f_addr = '0; d_addr = '0; d_wdata = '0; m_rdata = '0;
        #2;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done_err", {f_done, d_done, err}, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // single fetch
        f_req = 1'b1; f_addr = 32'h100;
        tick();
        chk("f_m_valid", m_valid, 1);
        chk("f_m_rw", m_rw, 1);
        chk("f_m_addr", m_addr, 32'h100);
        tick();
        tick();
        m_ready = 1'b0;
        tick();
        chk("f_hold_valid", m_valid, 1);
        tick();
        tick();
        chk("f_no_early_done", f_done, 0);
        m_ready = 1'b1; m_rdata = 32'hDEADBEEF;
        tick();
        chk("f_done", f_done, 1);
        chk("f_rdata", f_rdata, 32'hDEADBEEF);
        chk("f_valid_drop", m_valid, 0);
        chk("f_busy_release", busy, 1);
        f_req = 1'b0;
        tick();
        chk("f_done_single", f_done, 0);
        chk("f_busy_low", busy, 0);

        // store
        d_req = 1'b1; d_rw = 1'b0; d_addr = 32'h20; d_wdata = 32'h12345678;
        m_rdata = 32'hAAAA5555;
        tick();
        chk("s_m_rw", m_rw, 0);
        chk("s_m_addr", m_addr, 32'h20);
        chk("s_m_wdata", m_wdata, 32'h12345678);
        m_ready = 1'b0;
        tick();
        d_req = 1'b0; d_wdata = 32'h0BADF00D;
        tick();
        chk("s_wdata_stable", m_wdata, 32'h12345678);
        m_ready = 1'b1;
        tick();
        chk("s_d_done", d_done, 1);
        chk("s_d_rdata", d_rdata, 0);
        chk("s_f_quiet", f_done, 0);
        chk("s_f_rdata_hold", f_rdata, 32'hDEADBEEF);
        tick();
        chk("s_done_single", d_done, 0);

        // contention
        f_addr = 32'h300; d_addr = 32'h40; d_rw = 1'b1;
        f_req = 1'b1; d_req = 1'b1;
        run_one(32'hCAFE0001, was_data, ok);
        chk("c_ok0", ok, 1);
        chk("c_first_data", was_data, 1);
        chk("c_d_rdata", d_rdata, 32'hCAFE0001);
        run_one(32'hCAFE0002, was_data, ok);
        chk("c_ok1", ok, 1);
        chk("c_second_fetch", was_data, 0);
        chk("c_f_rdata", f_rdata, 32'hCAFE0002);

        // starvation: expect D,D,D,D,F,D
        f_req = 1'b1; d_req = 1'b1;
        order = '0;
        for (int i = 0; i < 6; i++) begin
            run_one(32'hCAFE0010 + i, was_data, ok);
            chk("v_ok", ok, 1);
            order[i] = was_data;
            d_req = 1'b1;
        end
        d_req = 1'b0;
        chk("v_order", order, 6'b101111);
        tick();

        // timeout with ready stuck high
        f_req = 1'b1; f_addr = 32'h500; m_ready = 1'b1; m_rdata = 32'h55AA55AA;
        tick();
        chk("t_valid", m_valid, 1);
        seen = 1'b0;
        for (int i = 1; i < 64; i++) begin
            tick();
            if (err === 1'b1 || f_done === 1'b1 || m_valid !== 1'b1) seen = 1'b1;
        end
        chk("t_not_early", seen, 0);
        tick();
        chk("t_err", err, 1);
        chk("t_f_done", f_done, 1);
        chk("t_valid_drop", m_valid, 0);
        chk("t_f_rdata", f_rdata, 0);
        f_req = 1'b0;
        tick();
        chk("t_err_single", {err, f_done}, 0);
        tick();

        // asynchronous reset mid-access
        f_req = 1'b1; f_addr = 32'h600;
        tick();
        m_ready = 1'b0;
        tick();
        chk("r_busy_before", busy, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_valid", m_valid, 0);
        chk("r_busy", busy, 0);
        chk("r_addr_rw", {m_addr, m_rw}, 0);
        chk("r_rdata", {f_rdata, d_rdata}, 0);
        f_req = 1'b0; m_ready = 1'b1;
        tick();
        chk("r_no_done", {f_done, d_done, err}, 0);
        reset = 1'b1;
        tick();
        f_req = 1'b1; f_addr = 32'h700;
        run_one(32'h13579BDF, was_data, ok);
        chk("r_after_ok", ok, 1);
        chk("r_after_fetch", was_data, 0);
        chk("r_after_rdata", f_rdata, 32'h13579BDF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
